// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, register index width,
// the shadow-stage record and the forwarding priority helper.
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  // EX operand mux select codes, named after the datapath register they pick.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WB2   = 2'd3
  } fwd_sel_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] dest;
    logic                 regwrite;
    logic                 is_load;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // True when the stage will write register r.
  function automatic logic writes_reg(input shadow_t s, input logic [REG_IDX_W-1:0] r);
    return s.valid & s.regwrite & (s.dest == r);
  endfunction

  // Select code for one ID source. The youngest producer wins; $0 and unused
  // sources always read the register file.
  function automatic fwd_sel_e fwd_code(input shadow_t ex, input shadow_t mem,
                                        input shadow_t wb,
                                        input logic [REG_IDX_W-1:0] src,
                                        input logic used);
    if (!used || src == '0)       return FWD_RF;
    if (writes_reg(ex, src))      return FWD_EXMEM;
    if (writes_reg(mem, src))     return FWD_MEMWB;
    if (writes_reg(wb, src))      return FWD_WB2;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// HI/LO busy counter: loads the multiply or divide latency when an operation
// issues, then counts down to zero. busy is high while the count is nonzero.
module muldiv_busy_ctr #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_div,
  output logic busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Load on issue, otherwise saturate-decrement toward zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for the 5-stage pipeline. A shadow pipeline
// of destination records drives the registered EX operand mux selects and
// the combinational load-use / HI-LO busy stall and bubble controls.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 id_regwrite,
  input  logic                 id_is_load,
  input  logic                 id_is_muldiv,
  input  logic                 id_is_div,
  input  logic                 id_use_hilo,
  input  logic                 ex_flush,
  output logic                 stall_if_id,
  output logic                 bubble_ex,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 muldiv_busy
);

  shadow_t  ex_q, mem_q, wb_q, wb2_q;
  shadow_t  id_entry;
  fwd_sel_e fwd_a_q, fwd_b_q;
  logic     load_use, hilo_hazard, hazard;
  logic     id_accept, muldiv_issue;

  // Hazard detection and the entry that moves from ID into EX this cycle.
  always_comb begin
    // NOTE: every output of this block is assigned unconditionally first so
    // no path leaves a value held, which would infer a latch.
    load_use     = 1'b0;
    hilo_hazard  = 1'b0;
    hazard       = 1'b0;
    stall_if_id  = 1'b0;
    bubble_ex    = 1'b0;
    id_accept    = 1'b0;
    muldiv_issue = 1'b0;
    id_entry     = SHADOW_EMPTY;

    if (ex_q.valid && ex_q.is_load && ex_q.dest != '0) begin
      load_use = (id_use_rs && id_rs == ex_q.dest) ||
                 (id_use_rt && id_rt == ex_q.dest);
    end
    hilo_hazard = muldiv_busy && (id_use_hilo || id_is_muldiv);
    hazard      = id_valid && (load_use || hilo_hazard);

    // A taken branch squashes ID, so it never waits behind a stall.
    stall_if_id  = hazard && !ex_flush;
    bubble_ex    = ex_flush || hazard;
    id_accept    = id_valid && !bubble_ex;
    muldiv_issue = id_accept && id_is_muldiv;

    if (id_accept) begin
      id_entry.valid    = 1'b1;
      id_entry.dest     = id_dest;
      id_entry.regwrite = id_regwrite;
      id_entry.is_load  = id_is_load;
    end
  end

  // Advance the shadow pipeline and register the selects for the entering op.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= SHADOW_EMPTY;
      mem_q   <= SHADOW_EMPTY;
      wb_q    <= SHADOW_EMPTY;
      wb2_q   <= SHADOW_EMPTY;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      wb2_q <= wb_q;
      if (id_accept) begin
        fwd_a_q <= fwd_code(ex_q, mem_q, wb_q, id_rs, id_use_rs);
        fwd_b_q <= fwd_code(ex_q, mem_q, wb_q, id_rt, id_use_rt);
      end else begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  muldiv_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_busy_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (muldiv_issue),
    .load_div (id_is_div),
    .busy     (muldiv_busy)
  );

  // The shadow stages shift one per cycle; WB2 is the entry that left WB.
  shadow_advance_a : assert property (@(posedge clk) disable iff (rst)
    $past(rst) || (wb2_q == $past(wb_q) && wb_q == $past(mem_q)));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a table of per-cycle ID records with
// hand-computed stall/bubble/select expectations, plus sequences for the
// multiply/divide busy window, flush during a load-use stall and reset
// during a divide.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       regwrite;
    logic       is_load;
    logic       is_muldiv;
    logic       is_div;
    logic       use_hilo;
    logic       flush;
    logic       exp_stall;
    logic       exp_bubble;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  localparam int NVEC = 29;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_is_load;
  logic       id_is_muldiv, id_is_div, id_use_hilo, ex_flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall_if_id, bubble_ex, muldiv_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_regwrite  (id_regwrite),
    .id_is_load   (id_is_load),
    .id_is_muldiv (id_is_muldiv),
    .id_is_div    (id_is_div),
    .id_use_hilo  (id_use_hilo),
    .ex_flush     (ex_flush),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .muldiv_busy  (muldiv_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t alu(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dest,
                               input logic [1:0] ea, input logic [1:0] eb);
    vec_t v;
    v = '0;
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.use_rs = 1'b1; v.use_rt = 1'b1;
    v.dest = dest; v.regwrite = 1'b1; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  function automatic vec_t ld(input logic [4:0] base, input logic [4:0] dest,
                              input logic [1:0] ea);
    vec_t v;
    v = '0;
    v.valid = 1'b1; v.rs = base; v.use_rs = 1'b1; v.dest = dest;
    v.regwrite = 1'b1; v.is_load = 1'b1; v.exp_a = ea;
    return v;
  endfunction

  function automatic vec_t muldiv(input logic is_div);
    vec_t v;
    v = '0;
    v.valid = 1'b1; v.rs = 5'd1; v.rt = 5'd2; v.use_rs = 1'b1; v.use_rt = 1'b1;
    v.is_muldiv = 1'b1; v.is_div = is_div;
    return v;
  endfunction

  function automatic vec_t hilo_read();
    vec_t v;
    v = '0;
    v.valid = 1'b1; v.dest = 5'd24; v.regwrite = 1'b1; v.use_hilo = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid     = v.valid;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_use_rs    = v.use_rs;
    id_use_rt    = v.use_rt;
    id_dest      = v.dest;
    id_regwrite  = v.regwrite;
    id_is_load   = v.is_load;
    id_is_muldiv = v.is_muldiv;
    id_is_div    = v.is_div;
    id_use_hilo  = v.use_hilo;
    ex_flush     = v.flush;
  endtask

  // One ID cycle: stall/bubble sampled mid-cycle, selects just after the edge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check({tag, " stall"},  int'(stall_if_id), int'(v.exp_stall));
    check({tag, " bubble"}, int'(bubble_ex),   int'(v.exp_bubble));
    @(posedge clk); #1;
    check({tag, " sel_a"}, int'(fwd_a_sel), int'(v.exp_a));
    check({tag, " sel_b"}, int'(fwd_b_sel), int'(v.exp_b));
  endtask

  // Issue a mult/div, then count the cycles a following HI/LO reader stalls.
  task automatic run_muldiv(input logic is_div, input int exp_lat, input string tag);
    int n;
    step(muldiv(is_div), {tag, " issue"});
    check({tag, " busy after issue"}, int'(muldiv_busy), 1);
    drive(hilo_read());
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!stall_if_id) break;
      n++;
      @(posedge clk); #1;
    end
    check({tag, " stall cycles"}, n, exp_lat);
    check({tag, " busy at release"}, int'(muldiv_busy), 0);
    @(posedge clk); #1;
    drive(idle());
  endtask

  initial begin
    // Back-to-back, distance 2 and 3, youngest-wins, $0, unused, non-writer.
    tbl[0]  = alu(5'd1,  5'd2,  5'd3,  2'd0, 2'd0);
    tbl[1]  = alu(5'd3,  5'd4,  5'd6,  2'd1, 2'd0);
    tbl[2]  = alu(5'd1,  5'd2,  5'd5,  2'd0, 2'd0);
    tbl[3]  = alu(5'd7,  5'd8,  5'd9,  2'd0, 2'd0);
    tbl[4]  = alu(5'd10, 5'd5,  5'd11, 2'd0, 2'd2);
    tbl[5]  = alu(5'd1,  5'd2,  5'd12, 2'd0, 2'd0);
    tbl[6]  = alu(5'd1,  5'd2,  5'd5,  2'd0, 2'd0);
    tbl[7]  = alu(5'd1,  5'd2,  5'd13, 2'd0, 2'd0);
    tbl[8]  = alu(5'd1,  5'd2,  5'd14, 2'd0, 2'd0);
    tbl[9]  = alu(5'd20, 5'd5,  5'd15, 2'd0, 2'd3);
    tbl[10] = alu(5'd1,  5'd2,  5'd5,  2'd0, 2'd0);
    tbl[11] = alu(5'd1,  5'd2,  5'd5,  2'd0, 2'd0);
    tbl[12] = alu(5'd5,  5'd5,  5'd16, 2'd1, 2'd1);
    tbl[13] = alu(5'd1,  5'd2,  5'd0,  2'd0, 2'd0);
    tbl[14] = alu(5'd0,  5'd0,  5'd17, 2'd0, 2'd0);
    tbl[15] = alu(5'd17, 5'd17, 5'd18, 2'd0, 2'd0);
    tbl[15].use_rs = 1'b0; tbl[15].use_rt = 1'b0;
    tbl[16] = alu(5'd1,  5'd2,  5'd19, 2'd0, 2'd0);
    tbl[16].regwrite = 1'b0;
    tbl[17] = alu(5'd19, 5'd18, 5'd30, 2'd0, 2'd2);
    // Load-use on rs, id_valid=0 never stalls, load to $0, unused source, rt.
    tbl[18] = ld(5'd1, 5'd4, 2'd0);
    tbl[19] = alu(5'd4, 5'd2, 5'd20, 2'd0, 2'd0);
    tbl[19].exp_stall = 1'b1; tbl[19].exp_bubble = 1'b1;
    tbl[20] = alu(5'd4, 5'd2, 5'd20, 2'd2, 2'd0);
    tbl[21] = alu(5'd20, 5'd20, 5'd20, 2'd0, 2'd0);
    tbl[21].valid = 1'b0;
    tbl[22] = ld(5'd1, 5'd0, 2'd0);
    tbl[23] = alu(5'd0, 5'd0, 5'd31, 2'd0, 2'd0);
    tbl[24] = ld(5'd1, 5'd21, 2'd0);
    tbl[25] = alu(5'd21, 5'd2, 5'd28, 2'd0, 2'd0);
    tbl[25].use_rs = 1'b0;
    tbl[26] = ld(5'd1, 5'd22, 2'd0);
    tbl[27] = alu(5'd1, 5'd22, 5'd29, 2'd0, 2'd0);
    tbl[27].exp_stall = 1'b1; tbl[27].exp_bubble = 1'b1;
    tbl[28] = alu(5'd1, 5'd22, 5'd29, 2'd0, 2'd2);

    // Reset state.
    rst = 1'b1;
    drive(idle());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset sel_a", int'(fwd_a_sel), 0);
    check("reset sel_b", int'(fwd_b_sel), 0);
    check("reset busy",  int'(muldiv_busy), 0);
    @(negedge clk);
    check("reset stall",  int'(stall_if_id), 0);
    check("reset bubble", int'(bubble_ex), 0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d busy", i), int'(muldiv_busy), 0);
    end

    // Flush arriving in a load-use stall cycle: squash, no stall, zero selects.
    begin
      vec_t v;
      step(ld(5'd1, 5'd23, 2'd0), "flush ld");
      v = alu(5'd23, 5'd2, 5'd27, 2'd0, 2'd0);
      v.flush = 1'b1; v.exp_bubble = 1'b1;
      step(v, "flush hit");
      step(alu(5'd23, 5'd2, 5'd27, 2'd2, 2'd0), "flush refetch");
    end

    run_muldiv(1'b1, 32, "div");
    run_muldiv(1'b0, 4,  "mul");

    // Reset with the divide counter at 17.
    step(muldiv(1'b1), "rdiv issue");
    drive(idle());
    repeat (13) begin
      @(posedge clk); #1;
    end
    step(alu(5'd1, 5'd2, 5'd25, 2'd0, 2'd0), "rdiv prod");
    step(alu(5'd25, 5'd2, 5'd26, 2'd1, 2'd0), "rdiv cons");
    check("rdiv busy before reset", int'(muldiv_busy), 1);
    drive(idle());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rdiv busy after reset",  int'(muldiv_busy), 0);
    check("rdiv sel_a after reset", int'(fwd_a_sel), 0);
    check("rdiv sel_b after reset", int'(fwd_b_sel), 0);
    step(hilo_read(), "rdiv mfhi");
    step(alu(5'd25, 5'd2, 5'd27, 2'd0, 2'd0), "rdiv cleared shadow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and hazard control for the 5-stage pipeline. It tracks the destination register of every in-flight instruction in a shadow pipeline. From that state it drives the 2-bit select codes of the EX-stage 4:1 operand muxes, and stalls or bubbles the front end on load-use and multiply/divide busy hazards. It sits beside the ID/EX pipeline register and produces the mux selects that the datapath consumes.

## Interface
Parameters:
- MUL_LAT, 4, cycles HI/LO stay busy after a multiply issues
- DIV_LAT, 32, cycles HI/LO stay busy after a divide issues

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register indices in ID
- id_use_rs, id_use_rt  in  1 each  instruction actually reads that source
- id_dest  in  5  destination register index
- id_regwrite  in  1  instruction writes id_dest
- id_is_load  in  1  instruction is a load
- id_is_muldiv  in  1  instruction is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_muldiv as a divide
- id_use_hilo  in  1  instruction is mfhi/mflo/mthi/mtlo
- ex_flush  in  1  branch resolved taken in EX; squash ID
- stall_if_id  out  1  hold PC and IF/ID (combinational)
- bubble_ex  out  1  load NOP into ID/EX (combinational)
- fwd_a_sel, fwd_b_sel  out  2 each  registered EX operand mux selects
- muldiv_busy  out  1  busy counter nonzero

## Operation
- Shadow stages EX, MEM, WB, WB2. Each stage holds {valid, dest, regwrite, is_load} and advances every cycle. Stage EX loads the ID entry, or an invalid entry when bubble_ex=1.
- Select codes: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result, 3 = WB2 (value written last cycle; covers the regfile read/write race).
- Code computation for each used source s of ID:
  - Code is 1 if EX.valid & EX.regwrite & EX.dest==s.
  - Otherwise code is 2 if the same test passes on MEM.
  - Otherwise code is 3 if it passes on WB.
  - Otherwise code is 0.
  - Youngest match wins. s==0 or the source unused -> 0.
  - The code is registered into fwd_*_sel when the ID entry enters EX. On a bubble, fwd_*_sel become 0.
- Load-use: EX.valid & EX.is_load & EX.dest!=0 & EX.dest matches a used ID source -> stall_if_id=1, bubble_ex=1.
- Mul/div busy:
  - The counter loads DIV_LAT (if id_is_div) or MUL_LAT on an accepted muldiv issue, otherwise decrements toward 0.
  - An issue is accepted when id_valid & id_is_muldiv & !stall_if_id & !ex_flush.
  - ID with (id_use_hilo | id_is_muldiv) while the counter != 0 -> stall_if_id=1, bubble_ex=1.
- ex_flush: ID entry is squashed, bubble_ex=1, stall_if_id=0 (flush overrides all stalls), no muldiv issue. Older stages advance unchanged.
- id_valid=0: treated as a bubble entry; it never stalls.

## Timing
- Reset (rst=1 at an edge):
  - All shadow stages invalid.
  - Counter 0.
  - fwd_a_sel=fwd_b_sel=0.
  - stall_if_id=bubble_ex=0 and muldiv_busy=0 in the following cycle.
- stall_if_id and bubble_ex are same-cycle combinational from ID inputs and current state.
- Selects become valid in the cycle the instruction is in EX, i.e. one clock after its ID cycle.
- Load-use costs exactly one stall cycle. On retry the load is in MEM, giving select 2 (the load result at MEM/WB).
- Busy counter: issue at edge t -> muldiv_busy high for exactly MUL_LAT/DIV_LAT cycles. A hilo user stalls until the counter reads 0.
- Reset mid-divide clears the counter immediately.
- Stall and flush in the same cycle -> flush behaviour.

## Structure
- Shared package `pipe_pkg`:
  - select codes FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2, FWD_WB2=3
  - REG_IDX_W=5
  - shadow-stage struct typedef
- Sub-module `muldiv_busy_ctr`: parameterized load/decrement counter with busy flag. Counter width is clog2(max(MUL_LAT,DIV_LAT)+1).

## Test plan
- Back-to-back ALU ops: add $3 followed by sub using $3 as rs -> fwd_a_sel=1 in the sub's EX cycle, no stall.
- Distance 2 and 3: producer of $5, one/two independent ops, then a reader of $5 in rt -> fwd_b_sel=2, then 3 in the respective cases. A reader of $0 after a write to $0 -> 0.
- Load-use: lw $4 then add using $4 -> one cycle of stall_if_id=1/bubble_ex=1, then fwd_a_sel=2.
- Divide then mflo: div issued, mflo next -> stall held 32 cycles, muldiv_busy drops, mflo proceeds. With MUL_LAT=4, mult -> 4 cycles.
- Flush during load-use stall: ex_flush=1 in the stall cycle -> stall_if_id=0, bubble_ex=1. Next-cycle selects are 0.
- Reset mid-divide at counter=17 -> next cycle muldiv_busy=0, all selects 0, a following mfhi is not stalled.
